// File: rtl/regfile_mp_if.sv
// Bundle of write, read, and scoreboard signals for the multi-port register file.
// The master drives addresses, data, and controls. The register file (slave)
// returns read data and per-port busy flags.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                    we0;
  logic [ADDR_W-1:0]       waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    we1;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic                    set_busy;
  logic [ADDR_W-1:0]       busy_addr;
  logic                    flush;
  logic [NREAD-1:0]        rbusy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output raddr, set_busy, busy_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  raddr, set_busy, busy_addr, flush,
    output rdata, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port general register file with two write ports, NREAD combinational
// read ports, internal same-cycle write forwarding, and a per-register busy
// scoreboard. The hazard unit uses the scoreboard to stall on outstanding producers.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  busy = '0;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              set_ok;
  logic [ADDR_W-1:0] ra [NREAD];

  // Qualify writes and busy-set requests. Register 0 is hardwired when ZERO_REG is set.
  always_comb begin
    wr0_ok = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    wr1_ok = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    set_ok = bus.set_busy && !((ZERO_REG != 0) && (bus.busy_addr == '0));
  end

  // Storage update. Port 1 is written last, so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[bus.waddr0] <= bus.wdata0;
      if (wr1_ok) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Next scoreboard value. A retiring write clears busy, and a new producer then
  // sets it again, so a set overrides a same-cycle clear. A flush clears every bit.
  always_comb begin
    busy_next = busy;
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      if (wr0_ok) busy_next[bus.waddr0] = 1'b0;
      if (wr1_ok) busy_next[bus.waddr1] = 1'b0;
      if (set_ok) busy_next[bus.busy_addr] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Read ports forward same-cycle writes, port 1 first. A register being written
  // this cycle is never reported busy. Forwarding is off while reset is held.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra[i] = bus.raddr[i*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra[i] == '0)) begin
        bus.rdata[i*DATA_W +: DATA_W] = '0;
        bus.rbusy[i] = 1'b0;
      end else if (reset) begin
        bus.rdata[i*DATA_W +: DATA_W] = regs[ra[i]];
        bus.rbusy[i] = 1'b0;
      end else if (wr1_ok && (bus.waddr1 == ra[i])) begin
        bus.rdata[i*DATA_W +: DATA_W] = bus.wdata1;
        bus.rbusy[i] = 1'b0;
      end else if (wr0_ok && (bus.waddr0 == ra[i])) begin
        bus.rdata[i*DATA_W +: DATA_W] = bus.wdata0;
        bus.rbusy[i] = 1'b0;
      end else begin
        bus.rdata[i*DATA_W +: DATA_W] = regs[ra[i]];
        bus.rbusy[i] = busy[ra[i]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. It runs two builds side by side:
//   dut2 - NREAD=2, ZERO_REG=1
//   dut4 - NREAD=4, ZERO_REG=0
// Both builds receive the same stimulus. Each build's outputs are compared
// against a per-build array model of registers and busy bits.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset = 1'b0;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus2 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4)) bus4 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .ZERO_REG(0)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            reset;
    logic            we0;
    logic [4:0]      waddr0;
    logic [31:0]     wdata0;
    logic            we1;
    logic [4:0]      waddr1;
    logic [31:0]     wdata1;
    logic            set_busy;
    logic [4:0]      busy_addr;
    logic            flush;
    logic [3:0][4:0] ra;
  } stim_t;

  logic [31:0] mreg  [2][32];
  logic        mbusy [2][32];
  stim_t       cur;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected read data: register 0 is hardwired in build 0; forwarding prefers port 1.
  function automatic logic [31:0] expData(int c, stim_t s, logic [4:0] a);
    if (c == 0 && a == 0) return 32'h0;
    if (s.reset) return mreg[c][a];
    if (s.we1 && s.waddr1 == a) return s.wdata1;
    if (s.we0 && s.waddr0 == a) return s.wdata0;
    return mreg[c][a];
  endfunction

  function automatic logic expBusy(int c, stim_t s, logic [4:0] a);
    if (c == 0 && a == 0) return 1'b0;
    if (s.reset) return 1'b0;
    if ((s.we1 && s.waddr1 == a) || (s.we0 && s.waddr0 == a)) return 1'b0;
    return mbusy[c][a];
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    cur = s;
    reset = s.reset;
    bus2.we0 = s.we0; bus2.waddr0 = s.waddr0; bus2.wdata0 = s.wdata0;
    bus2.we1 = s.we1; bus2.waddr1 = s.waddr1; bus2.wdata1 = s.wdata1;
    bus2.set_busy = s.set_busy; bus2.busy_addr = s.busy_addr; bus2.flush = s.flush;
    bus2.raddr = s.ra[1:0];
    bus4.we0 = s.we0; bus4.waddr0 = s.waddr0; bus4.wdata0 = s.wdata0;
    bus4.we1 = s.we1; bus4.waddr1 = s.waddr1; bus4.wdata1 = s.wdata1;
    bus4.set_busy = s.set_busy; bus4.busy_addr = s.busy_addr; bus4.flush = s.flush;
    bus4.raddr = s.ra;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("d2_rdata%0d", i), bus2.rdata[i*32 +: 32], expData(0, s, s.ra[i]));
      checkOutput($sformatf("d2_rbusy%0d", i), {31'b0, bus2.rbusy[i]}, {31'b0, expBusy(0, s, s.ra[i])});
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("d4_rdata%0d", i), bus4.rdata[i*32 +: 32], expData(1, s, s.ra[i]));
      checkOutput($sformatf("d4_rbusy%0d", i), {31'b0, bus4.rbusy[i]}, {31'b0, expBusy(1, s, s.ra[i])});
    end
  endtask

  // Advance one clock and apply the architectural update rules to both models.
  task automatic stepClock();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (cur.reset) begin
        for (int a = 0; a < 32; a++) begin
          mreg[c][a] = 32'h0;
          mbusy[c][a] = 1'b0;
        end
      end else begin
        if (cur.we0 && !(c == 0 && cur.waddr0 == 0)) mreg[c][cur.waddr0] = cur.wdata0;
        if (cur.we1 && !(c == 0 && cur.waddr1 == 0)) mreg[c][cur.waddr1] = cur.wdata1;
        if (cur.flush) begin
          for (int a = 0; a < 32; a++) mbusy[c][a] = 1'b0;
        end else begin
          if (cur.we0) mbusy[c][cur.waddr0] = 1'b0;
          if (cur.we1) mbusy[c][cur.waddr1] = 1'b0;
          if (cur.set_busy && !(c == 0 && cur.busy_addr == 0)) mbusy[c][cur.busy_addr] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.reset     = ($urandom_range(0, 49) == 0);
    s.we0       = 1'($urandom_range(0, 1));
    s.waddr0    = randAddr();
    s.wdata0    = $urandom;
    s.we1       = 1'($urandom_range(0, 1));
    s.waddr1    = randAddr();
    s.wdata1    = $urandom;
    s.set_busy  = ($urandom_range(0, 2) != 0);
    s.busy_addr = randAddr();
    s.flush     = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < 4; i++) s.ra[i] = randAddr();
    return s;
  endfunction

  // Safety net in case the run stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++) begin
        mreg[c][a] = 32'h0;
        mbusy[c][a] = 1'b0;
      end

    // Reset, with a write attempted to reg 3 and all addresses swept.
    for (int a = 0; a < 32; a++) begin
      s = '0; s.reset = 1'b1;
      s.we0 = 1'b1; s.waddr0 = 5'd3; s.wdata0 = 32'hDEADBEEF;
      s.ra[0] = 5'(a); s.ra[1] = 5'(31 - a); s.ra[2] = 5'(a); s.ra[3] = 5'd3;
      applyStimulus(s);
      stepClock();
    end
    s = '0; s.ra[0] = 5'd3;
    applyStimulus(s);
    checkOutput("t1_reg3_after_reset", bus2.rdata[31:0], 32'h0);
    stepClock();

    // Forward, then stored value.
    s = '0; s.we0 = 1'b1; s.waddr0 = 5'd5; s.wdata0 = 32'h12345678; s.ra[0] = 5'd5;
    applyStimulus(s);
    checkOutput("t2_fwd", bus2.rdata[31:0], 32'h12345678);
    stepClock();
    s = '0; s.ra[0] = 5'd5;
    applyStimulus(s);
    checkOutput("t2_stored", bus2.rdata[31:0], 32'h12345678);
    stepClock();

    // Dual write to one address, then a write to register 0.
    s = '0; s.we0 = 1'b1; s.waddr0 = 5'd7; s.wdata0 = 32'hAAAA0000;
    s.we1 = 1'b1; s.waddr1 = 5'd7; s.wdata1 = 32'h5555FFFF; s.ra[0] = 5'd7;
    applyStimulus(s);
    checkOutput("t3_dual_fwd", bus2.rdata[31:0], 32'h5555FFFF);
    stepClock();
    s = '0; s.we0 = 1'b1; s.waddr0 = 5'd0; s.wdata0 = 32'hFFFFFFFF; s.ra[0] = 5'd7; s.ra[1] = 5'd0;
    applyStimulus(s);
    checkOutput("t3_dual_stored", bus2.rdata[31:0], 32'h5555FFFF);
    checkOutput("t3_zero_fwd", bus2.rdata[63:32], 32'h0);
    stepClock();
    s = '0; s.ra[1] = 5'd0;
    applyStimulus(s);
    checkOutput("t3_zero_stored", bus2.rdata[63:32], 32'h0);
    stepClock();

    // Busy set, then cleared by a write.
    s = '0; s.set_busy = 1'b1; s.busy_addr = 5'd9;
    applyStimulus(s);
    stepClock();
    s = '0; s.ra[1] = 5'd9;
    applyStimulus(s);
    checkOutput("t4_busy_set", {31'b0, bus2.rbusy[1]}, 32'h1);
    stepClock();
    s = '0; s.we1 = 1'b1; s.waddr1 = 5'd9; s.wdata1 = 32'h42; s.ra[1] = 5'd9;
    applyStimulus(s);
    checkOutput("t4_busy_fwd", {31'b0, bus2.rbusy[1]}, 32'h0);
    checkOutput("t4_data_fwd", bus2.rdata[63:32], 32'h42);
    stepClock();
    s = '0; s.ra[1] = 5'd9;
    applyStimulus(s);
    checkOutput("t4_busy_cleared", {31'b0, bus2.rbusy[1]}, 32'h0);
    stepClock();

    // A set overrides a same-cycle clear. A flush overrides a set.
    s = '0; s.set_busy = 1'b1; s.busy_addr = 5'd4; s.we0 = 1'b1; s.waddr0 = 5'd4; s.wdata0 = 32'h77;
    applyStimulus(s);
    stepClock();
    s = '0; s.ra[0] = 5'd4; s.flush = 1'b1; s.set_busy = 1'b1; s.busy_addr = 5'd6;
    applyStimulus(s);
    checkOutput("t5_set_wins", {31'b0, bus2.rbusy[0]}, 32'h1);
    checkOutput("t5_reg4", bus2.rdata[31:0], 32'h77);
    stepClock();
    s = '0; s.ra[0] = 5'd4; s.ra[1] = 5'd6;
    applyStimulus(s);
    checkOutput("t5_flush", {30'b0, bus2.rbusy}, 32'h0);
    stepClock();

    // Register 0 behaves as an ordinary register in the 4-port, ZERO_REG=0 build.
    s = '0; s.we0 = 1'b1; s.waddr0 = 5'd0; s.wdata0 = 32'h1;
    applyStimulus(s);
    stepClock();
    s = '0; s.set_busy = 1'b1; s.busy_addr = 5'd0;
    applyStimulus(s);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t6_r0_port%0d", i), bus4.rdata[i*32 +: 32], 32'h1);
    stepClock();
    s = '0;
    applyStimulus(s);
    checkOutput("t6_rbusy_all", {28'b0, bus4.rbusy}, 32'hF);
    checkOutput("t6_zr_not_busy", {30'b0, bus2.rbusy}, 32'h0);
    stepClock();

    // Randomized traffic against the models.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(randStim());
      stepClock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general register file for the pipelined core. It replaces the fixed 2-read/1-write file.
- Provides NREAD combinational read ports and two synchronous write ports with defined collision priority.
- Forwards same-cycle writes to the read ports internally, so no external bypass controls are needed.
- Holds a per-register busy scoreboard that the hazard unit uses to stall on outstanding producers (load-use, multi-cycle ops).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high; clears all registers and all busy bits
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NREAD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
set_busy  in  1  mark busy_addr as having an outstanding producer
busy_addr  in  ADDR_W  register to mark busy
flush  in  1  clear all busy bits (pipeline flush)
rbusy  out  NREAD  per read port: addressed register still pending

Behaviour:
- Storage: array of 2**ADDR_W x DATA_W. Busy vector of 2**ADDR_W bits.
- Reset, on posedge with reset=1:
  - all registers := 0, all busy := 0;
  - writes, set_busy and flush in that cycle are ignored.
- Power-up initial value is 0 for all registers and busy bits, for simulation.
- Write, on posedge: port k updates reg[waddrk] := wdatak when wek=1.
  - With ZERO_REG=1, a write to address 0 is dropped.
  - Both ports enabled to the same address: port 1 wins; port 0 data is discarded.
- Read is combinational, zero latency, in priority order:
  - ZERO_REG=1 and raddr_i=0 -> 0;
  - else we1 && waddr1==raddr_i (and the write is not dropped) -> wdata1;
  - else we0 && waddr0==raddr_i -> wdata0;
  - else reg[raddr_i].
- Forwarding is suppressed during reset=1, and rdata then shows stored contents.
- Busy update, on posedge when reset=0, in priority order:
  - flush=1 -> all busy := 0; set_busy in the same cycle is ignored.
  - Otherwise, a write on either port clears busy[waddrk].
  - Then set_busy sets busy[busy_addr]. Set wins over a same-cycle clear of the same address, because the new producer supersedes the retiring one.
  - With ZERO_REG=1, set_busy to address 0 is ignored.
- rbusy_i = busy[raddr_i] && !(same-cycle enabled write to raddr_i, either port).
  - A register being written this cycle is not reported busy; its data is forwarded.
  - rbusy_i is 0 when ZERO_REG=1 and raddr_i=0, and 0 while reset=1.
- Read ports are independent: all NREAD ports may address the same register.
- Outputs after reset: rdata = 0 for all ports, rbusy = 0.

Test Plan:
1. Reset then read all 32 addresses on both ports -> rdata=0, rbusy=0. Hold reset with we0=1, waddr0=3, wdata0=0xDEADBEEF -> reg3 stays 0 after reset deasserts.
2. we0=1, waddr0=5, wdata0=0x12345678 with raddr0=5 in the same cycle -> rdata0=0x12345678 before the edge. Next cycle with we0=0 -> rdata0 still 0x12345678.
3. Dual write to addr 7 (wdata0=0xAAAA0000, wdata1=0x5555FFFF) -> forwarded value and stored value are both 0x5555FFFF. Write 0xFFFFFFFF to addr 0 -> reads 0 (ZERO_REG=1).
4. set_busy, busy_addr=9 -> next cycle raddr1=9 gives rbusy[1]=1. Then we1=1, waddr1=9, wdata1=0x42 -> rbusy[1]=0 in that cycle, rdata1=0x42, busy cleared after the edge.
5. Same cycle: set_busy on addr 4 and we0 write to addr 4 -> after the edge busy[4]=1 with reg4 updated. Then flush=1 together with set_busy on addr 6 -> busy[4]=busy[6]=0.
6. NREAD=4, ZERO_REG=0 build: write 0x1 to addr 0, read addr 0 on all four ports -> all return 0x1; set_busy addr 0 -> rbusy=4'b1111.
